// File: rtl/program_loader.sv
// program_loader: receives a nibble stream (length, data, optional checksum) and writes program memory.
// Checksum verification is compiled in with `define PROGRAM_LOADER_CHECKSUM_EN.
module program_loader (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_req,
    input  logic       nib_valid,
    input  logic [3:0] nib_data,
    output logic       nib_ready,
    output logic       pm_wr_en,
    output logic [7:0] pm_wr_addr,
    output logic [7:0] pm_wr_data,
    output logic       run,
    output logic [7:0] load_count,
    output logic       load_err
);
    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, RUN
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        , CSUM_HI, CSUM_LO, ERROR
`endif
    } state_t;

    state_t state, nxt;
    logic [3:0] hi;
    logic [7:0] len;
    logic [7:0] byte_in;
    logic xfer, last;

    assign xfer    = nib_valid & nib_ready;
    assign byte_in = {hi, nib_data};
    // load_count doubles as the index of the byte being assembled; length 0 wraps to 256
    assign last    = load_count == len - 8'd1;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] csum;
`else
    assign load_err = 1'b0;
`endif

    always_comb begin
        nxt = state;
        case (state)
            IDLE, RUN: nxt = load_req ? LEN_HI : state;
            LEN_HI:    nxt = xfer ? LEN_LO : state;
            LEN_LO:    nxt = xfer ? DATA_HI : state;
            DATA_HI:   nxt = xfer ? DATA_LO : state;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            DATA_LO:   nxt = !xfer ? state : last ? CSUM_HI : DATA_HI;
            CSUM_HI:   nxt = xfer ? CSUM_LO : state;
            CSUM_LO:   nxt = !xfer ? state : csum == byte_in ? RUN : ERROR;
`else
            DATA_LO:   nxt = !xfer ? state : last ? RUN : DATA_HI;
`endif
            default:   nxt = state;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            nib_ready  <= 1'b0;
            pm_wr_en   <= 1'b0;
            pm_wr_addr <= 8'h00;
            pm_wr_data <= 8'h00;
            run        <= 1'b0;
            load_count <= 8'h00;
            hi         <= 4'h0;
            len        <= 8'h00;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            load_err   <= 1'b0;
            csum       <= 8'h00;
`endif
        end else begin
            state     <= nxt;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            nib_ready <= nxt inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM_HI, CSUM_LO};
`else
            nib_ready <= nxt inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO};
`endif
            run       <= nxt == RUN;
            pm_wr_en  <= 1'b0;
            if (xfer) hi <= nib_data;
            if (state == LEN_LO && xfer) len <= byte_in;
            if (nxt == LEN_HI) load_count <= 8'h00;
            if (state == DATA_LO && xfer) begin
                pm_wr_en   <= 1'b1;
                pm_wr_addr <= load_count;
                pm_wr_data <= byte_in;
                load_count <= load_count + 8'd1;
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            if (nxt == LEN_HI) begin
                csum     <= 8'h00;
                load_err <= 1'b0;
            end
            if (state == DATA_LO && xfer) csum <= csum + byte_in;
            if (nxt == ERROR) load_err <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized and directed sessions checked against a byte-level memory model.
module tb_program_loader;
    logic       clk = 1'b0;
    logic       reset, load_req, nib_valid;
    logic [3:0] nib_data;
    logic       nib_ready, pm_wr_en, run, load_err;
    logic [7:0] pm_wr_addr, pm_wr_data, load_count;

    int n_cmp = 0, n_bad = 0;
    logic [15:0] wq[$];
    logic [7:0]  mem[256];
    logic [7:0]  exp_mem[256];
    logic        prev_en = 1'b0;

    program_loader dut (
        .clk(clk), .reset(reset), .load_req(load_req), .nib_valid(nib_valid), .nib_data(nib_data),
        .nib_ready(nib_ready), .pm_wr_en(pm_wr_en), .pm_wr_addr(pm_wr_addr), .pm_wr_data(pm_wr_data),
        .run(run), .load_count(load_count), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // program memory model fed by the write port; also catches back-to-back strobes
    always @(negedge clk) begin
        if (pm_wr_en) begin
            chk("pulse_width", {31'b0, prev_en}, 0);
            wq.push_back({pm_wr_addr, pm_wr_data});
            mem[pm_wr_addr] = pm_wr_data;
        end
        prev_en = pm_wr_en;
    end

    task automatic rst_chk(input string tag);
        chk({tag, "_ready"}, {31'b0, nib_ready}, 0);
        chk({tag, "_wr_en"}, {31'b0, pm_wr_en}, 0);
        chk({tag, "_addr"}, {24'b0, pm_wr_addr}, 0);
        chk({tag, "_data"}, {24'b0, pm_wr_data}, 0);
        chk({tag, "_run"}, {31'b0, run}, 0);
        chk({tag, "_count"}, {24'b0, load_count}, 0);
        chk({tag, "_err"}, {31'b0, load_err}, 0);
    endtask

    task automatic nib(input logic [3:0] n, input int stall);
        int t = 0;
        nib_valid = 1'b1;
        nib_data  = n;
        while (!nib_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("handshake_timeout", 1, 0);
        @(negedge clk);
        nib_valid = 1'b0;
        nib_data  = 4'($urandom);
        repeat (stall) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int stall);
        nib(b[7:4], stall);
        nib(b[3:0], stall);
    endtask

    task automatic start_load();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        chk("run_low_after_req", {31'b0, run}, 0);
        chk("ready_in_len", {31'b0, nib_ready}, 1);
        chk("count_cleared", {24'b0, load_count}, 0);
    endtask

    task automatic session(input logic [7:0] bytes[$], input int stall, input bit bad_cs);
        int n = bytes.size();
        int d = 0;
        logic [7:0] sum = 8'h00;
        wq.delete();
        start_load();
        send_byte(n[7:0], stall);
        foreach (bytes[i]) begin
            send_byte(bytes[i], stall);
            sum += bytes[i];
            exp_mem[i] = bytes[i];
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(bad_cs ? 8'h00 : sum, stall);
`endif
        chk("run_after_load", {31'b0, run}, {31'b0, !bad_cs});
        chk("load_count", {24'b0, load_count}, {24'b0, n[7:0]});
        chk("load_err", {31'b0, load_err}, {31'b0, bad_cs});
        repeat (2) @(negedge clk);
        chk("write_count", wq.size(), n);
        foreach (bytes[i]) if (i < wq.size()) chk($sformatf("write_%0d", i), {16'b0, wq[i]}, {16'b0, i[7:0], bytes[i]});
        for (int k = 0; k < 256; k++) if (mem[k] !== exp_mem[k]) d++;
        chk("mem_image", d, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] q[$];
        for (int k = 0; k < 256; k++) begin
            mem[k] = 8'h00;
            exp_mem[k] = 8'h00;
        end
        reset = 1'b1; load_req = 1'b0; nib_valid = 1'b0; nib_data = 4'h0;
        #12 rst_chk("reset");
        @(negedge clk) reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_ready", {31'b0, nib_ready}, 0);
        chk("idle_run", {31'b0, run}, 0);

        q = '{8'hC8, 8'h12, 8'hFF};
        session(q, 0, 1'b0);
        session(q, 5, 1'b0);
        q = '{8'hA5};
        session(q, 0, 1'b0);
        q.delete();
        for (int k = 0; k < 256; k++) q.push_back(k[7:0]);
        session(q, 0, 1'b0);

        repeat (6) begin
            q.delete();
            repeat ($urandom_range(1, 40)) q.push_back(8'($urandom));
            session(q, $urandom_range(0, 3), 1'b0);
        end

        // reset in DATA_HI after two bytes of a four-byte load
        start_load();
        send_byte(8'h04, 0);
        send_byte(8'h5A, 0);
        send_byte(8'hC3, 0);
        exp_mem[0] = 8'h5A;
        exp_mem[1] = 8'hC3;
        #3 reset = 1'b1;
        #1 rst_chk("async_reset");
        @(negedge clk) reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_reset_idle_ready", {31'b0, nib_ready}, 0);
        chk("post_reset_idle_run", {31'b0, run}, 0);

        q.delete();
        repeat ($urandom_range(1, 20)) q.push_back(8'($urandom));
        session(q, 1, 1'b0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        q = '{8'hC8, 8'h12, 8'hFF};
        session(q, 0, 1'b1);
        load_req = 1'b1;
        repeat (4) @(negedge clk);
        load_req = 1'b0;
        chk("error_ready", {31'b0, nib_ready}, 0);
        chk("error_run", {31'b0, run}, 0);
        chk("error_sticky", {31'b0, load_err}, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
